pipe_stage_reg: RTL and testbench

//   Parametrised elastic pipeline register for any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/pipe_stage_reg_if.sv | 25 ++
 rtl/pipe_skid_slot.sv | 31 +++
 rtl/pipe_stage_reg.sv | 139 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle bit positions, default bundle widths,
// the all-zero control nop, and the occupancy states of an elastic stage register.
package pipe_pkg;

    localparam int PIPE_CTRL_W  = 8;
    localparam int PIPE_DATA_W  = 138;
    localparam int PIPE_COUNT_W = 32;

    localparam int CTRL_REG_DEST   = 0;
    localparam int CTRL_ALU_OP     = 1;
    localparam int CTRL_ALU_SRC    = 2;
    localparam int CTRL_BRANCH     = 3;
    localparam int CTRL_MEM_READ   = 4;
    localparam int CTRL_MEM_WRITE  = 5;
    localparam int CTRL_MEM_TO_REG = 6;
    localparam int CTRL_REG_WRITE  = 7;

    // A bubble carries this, so no write, branch or memory access fires downstream.
    localparam logic [PIPE_CTRL_W-1:0] CTRL_NOP = '0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    // Entries destroyed by a flush; an entry consumed downstream in the same cycle is not lost.
    function automatic logic [1:0] flush_kill(input logic main_v, input logic skid_v,
                                              input logic out_fire);
        return {1'b0, main_v} + {1'b0, skid_v} - {1'b0, out_fire};
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Stage-boundary handshake bundle. The upstream side uses in_*, the downstream side out_*;
// a transfer happens on a side in every cycle where its valid and ready are both high.
interface pipe_stage_reg_if #(
    parameter int CTRL_W = pipe_pkg::PIPE_CTRL_W,
    parameter int DATA_W = pipe_pkg::PIPE_DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] ctrl_in;
    logic [DATA_W-1:0] data_in;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] ctrl_out;
    logic [DATA_W-1:0] data_out;

    modport slave (
        input  in_valid, ctrl_in, data_in, out_ready,
        output in_ready, out_valid, ctrl_out, data_out
    );

    modport master (
        output in_valid, ctrl_in, data_in, out_ready,
        input  in_ready, out_valid, ctrl_out, data_out
    );
endinterface

// File: rtl/pipe_skid_slot.sv
// One storage entry of the stage: a WIDTH-bit register with a valid bit.
// Clearing drops only the valid bit, so the payload keeps its last value.
module pipe_skid_slot #(
    parameter int WIDTH = 146
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_d,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_q
);
    logic             r_valid;
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_q     <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_q     <= i_d;
        end
    end

    assign o_valid = r_valid;
    assign o_q     = r_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with a main entry and a skid entry, registered in_ready,
// flush, and bubble masking of ctrl_out. PIPE_STAGE_PERF_EN adds stall/flush counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W  = PIPE_CTRL_W,
    parameter int DATA_W  = PIPE_DATA_W
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int COUNT_W = PIPE_COUNT_W
`endif
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    pipe_stage_reg_if.slave     bus,
    output pipe_state_e         dbg_state
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [COUNT_W-1:0]  stall_cnt,
    output logic [COUNT_W-1:0]  flush_cnt
`endif
);
    localparam int W = CTRL_W + DATA_W;

    pipe_state_e r_state, w_next;
    logic        r_in_ready;
    logic        w_in_fire, w_out_fire;
    logic        w_main_load, w_main_clear, w_skid_load, w_skid_clear;
    logic        w_main_valid, w_skid_valid;
    logic [W-1:0] w_in_bus, w_main_d, w_main_q, w_skid_q;

    assign w_in_bus   = {bus.ctrl_in, bus.data_in};
    assign w_in_fire  = bus.in_valid & r_in_ready;
    assign w_out_fire = w_main_valid & bus.out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != ST_FULL);
        end
    end

    always_comb begin
        w_next       = r_state;
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        w_main_d     = w_in_bus;
        if (flush) begin
            // A same-cycle upstream handshake completes but is simply not stored.
            w_next       = ST_EMPTY;
            w_main_clear = 1'b1;
            w_skid_clear = w_skid_valid;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_load = 1'b1;
                        w_next      = ST_HALF;
                    end
                end
                ST_HALF: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_load = 1'b1;
                    end else if (w_in_fire) begin
                        w_skid_load = 1'b1;
                        w_next      = ST_FULL;
                    end else if (w_out_fire) begin
                        w_main_clear = 1'b1;
                        w_next       = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_main_d     = w_skid_q;
                        w_main_load  = 1'b1;
                        w_skid_clear = 1'b1;
                        w_next       = ST_HALF;
                    end
                end
                default: w_next = ST_EMPTY;
            endcase
        end
    end

    pipe_skid_slot #(.WIDTH(W)) u_main (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_d     (w_main_d),
        .o_valid (w_main_valid),
        .o_q     (w_main_q)
    );

    pipe_skid_slot #(.WIDTH(W)) u_skid (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_d     (w_in_bus),
        .o_valid (w_skid_valid),
        .o_q     (w_skid_q)
    );

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = w_main_valid;
    assign bus.ctrl_out  = w_main_valid ? w_main_q[W-1:DATA_W] : CTRL_W'(CTRL_NOP);
    assign bus.data_out  = w_main_q[DATA_W-1:0];
    assign dbg_state     = r_state;

`ifdef PIPE_STAGE_PERF_EN
    logic [COUNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic [COUNT_W:0]   w_flush_sum;
    logic [1:0]         w_killed;

    assign w_killed    = flush ? flush_kill(w_main_valid, w_skid_valid, w_out_fire) : 2'd0;
    assign w_flush_sum = {1'b0, r_flush_cnt} + (COUNT_W+1)'(w_killed);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_main_valid && !bus.out_ready && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + COUNT_W'(1);
            r_flush_cnt <= w_flush_sum[COUNT_W] ? '1 : w_flush_sum[COUNT_W-1:0];
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios then random valid/ready/flush traffic,
// all checked each cycle against a queue model of the stage contents.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int CW = 8;
    localparam int DW = 138;
    localparam int W  = CW + DW;

    logic clock = 1'b0;
    logic reset;
    logic flush;
    always #5 clock = ~clock;

    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus ();
    pipe_state_e dbg_state;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    pipe_stage_reg dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    // Reference model: the stage is a FIFO of at most two entries.
    logic [W-1:0]  exp_q[$];
    logic [DW-1:0] m_last_data;
    int unsigned   m_stall, m_flush;
    bit            m_init;
    int            n_tests, n_fail;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [W-1:0]  front;
        logic          exp_v;
        logic [CW-1:0] exp_c;
        logic [DW-1:0] exp_d;
        pipe_state_e   exp_s;
        int            sz;
        sz    = exp_q.size();
        exp_v = (sz != 0);
        if (exp_v) begin
            front       = exp_q[0];
            exp_c       = front[W-1:DW];
            exp_d       = front[DW-1:0];
            m_last_data = exp_d;
        end else begin
            exp_c = '0;
            exp_d = m_last_data;
        end
        exp_s = (sz == 0) ? ST_EMPTY : (sz == 1) ? ST_HALF : ST_FULL;
        chk("out_valid", bus.out_valid, exp_v);
        chk("ctrl_out",  bus.ctrl_out,  exp_c);
        chk("data_out",  bus.data_out,  exp_d);
        chk("in_ready",  bus.in_ready,  sz < 2);
        chk("state",     dbg_state,     exp_s);
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
`endif
    endtask

    // Check at the falling edge, then advance the model across the rising edge.
    task automatic tick();
        bit in_fire, out_fire;
        int sz;
        if (m_init) check_outputs();
        sz       = exp_q.size();
        in_fire  = bus.in_valid && (sz < 2);
        out_fire = (sz > 0) && bus.out_ready;
        @(posedge clock);
        if (reset) begin
            exp_q.delete();
            m_last_data = '0;
            m_stall     = 0;
            m_flush     = 0;
            m_init      = 1'b1;
        end else begin
            if (sz > 0 && !bus.out_ready) m_stall++;
            if (flush) begin
                m_flush += sz - (out_fire ? 1 : 0);
                exp_q.delete();
            end else begin
                if (out_fire) void'(exp_q.pop_front());
                if (in_fire) exp_q.push_back({bus.ctrl_in, bus.data_in});
            end
        end
        @(negedge clock);
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic rdy);
        bus.in_valid  = v;
        bus.ctrl_in   = c;
        bus.data_in   = d;
        bus.out_ready = rdy;
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_init  = 1'b0;
        reset   = 1'b1;
        flush   = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        @(negedge clock);
        tick();
        tick();
        reset = 1'b0;

        // Streaming at full rate.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, CW'(i), DW'(i), 1'b1);
            tick();
        end
        drive(1'b0, '0, '0, 1'b1);
        tick();
        tick();

        // Stall with A, B, then release.
        drive(1'b1, 8'h0A, DW'(16'hAAAA), 1'b0); tick();
        drive(1'b1, 8'h0B, DW'(16'hBBBB), 1'b0); tick();
        drive(1'b0, '0, '0, 1'b0); tick(); tick();
        drive(1'b0, '0, '0, 1'b1); tick(); tick(); tick();

        // Flush with both entries full and C offered in the same cycle.
        drive(1'b1, 8'h1A, DW'(16'h1111), 1'b0); tick();
        drive(1'b1, 8'h1B, DW'(16'h2222), 1'b0); tick();
        drive(1'b1, 8'h1C, DW'(16'h3333), 1'b0); flush = 1'b1; tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b1); tick(); tick();

        // Bubble masking of an all-ones control bundle.
        drive(1'b0, 8'hFF, DW'(16'h5555), 1'b1); tick(); tick();
        drive(1'b1, 8'hFF, DW'(16'h6666), 1'b1); tick();
        drive(1'b0, 8'hFF, '0, 1'b1); tick(); tick();

        // Reset while full and stalled.
        drive(1'b1, 8'h21, DW'(16'h7777), 1'b0); tick();
        drive(1'b1, 8'h22, DW'(16'h8888), 1'b0); tick();
        drive(1'b0, '0, '0, 1'b0); tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b1); tick(); tick();

        // Random traffic with occasional flushes.
        for (int n = 0; n < 10000; n++) begin
            drive($urandom_range(0, 3) != 0, CW'($urandom), rand_data(),
                  $urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 63) == 0);
            tick();
        end
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b1);
        for (int n = 0; n < 4; n++) tick();
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
